// File: rtl/nbbpu_ram_pkg.sv
// Shared types and constants for the NBBPU data RAM arbiter.
package nbbpu_ram_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 16;

  localparam logic PORT_LOADER = 1'b0;
  localparam logic PORT_CPU    = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/ram_arbiter_pick.sv
// Combinational winner select between loader (port 0) and CPU (port 1).
// On a tie the port that was not served last wins.
module ram_arbiter_pick
  import nbbpu_ram_pkg::*;
(
  input  logic request0,
  input  logic request1,
  input  logic last_served,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = request0 | request1;
    winner = PORT_LOADER;
    if (request0 && request1) begin
      winner = (last_served == PORT_LOADER) ? PORT_CPU : PORT_LOADER;
    end else if (request1) begin
      winner = PORT_CPU;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the single-port NBBPU data RAM: one access per two clocks.
// Define RAM_ARBITER_ROUND_ROBIN_EN for round-robin ties; otherwise port 0 always wins ties.
module ram_arbiter
  import nbbpu_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  p0_request,
  input  logic                  p0_write,
  input  logic [ADDR_WIDTH-1:0] p0_address,
  input  logic [DATA_WIDTH-1:0] p0_write_data,
  output logic                  p0_grant,
  output logic                  p0_done,
  output logic [DATA_WIDTH-1:0] p0_read_data,
  input  logic                  p1_request,
  input  logic                  p1_write,
  input  logic [ADDR_WIDTH-1:0] p1_address,
  input  logic [DATA_WIDTH-1:0] p1_write_data,
  output logic                  p1_grant,
  output logic                  p1_done,
  output logic [DATA_WIDTH-1:0] p1_read_data,
  output logic                  ram_write_enable,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  input  logic [DATA_WIDTH-1:0] ram_read_data
);

  state_t                state;
  state_t                state_next;
  logic                  load;
  logic                  pick_valid;
  logic                  pick_port;
  logic                  last_port;
  logic                  owner;
  logic                  lat_write;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_address;
  logic [DATA_WIDTH-1:0] sel_write_data;

  ram_arbiter_pick u_pick (
    .request0    (p0_request),
    .request1    (p1_request),
    .last_served (last_port),
    .valid       (pick_valid),
    .winner      (pick_port)
  );

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
  // Last-served pointer; reset value makes the first tie go to the loader.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_port <= PORT_CPU;
    end else if (load) begin
      last_port <= pick_port;
    end
  end
`else
  assign last_port = PORT_CPU;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DONE samples requests exactly like IDLE so back-to-back accesses take two clocks.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (pick_valid) begin
          load       = 1'b1;
          state_next = ACCESS;
        end else begin
          state_next = IDLE;
        end
      end
      ACCESS:  state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sel_write      = p0_write;
    sel_address    = p0_address;
    sel_write_data = p0_write_data;
    if (pick_port == PORT_CPU) begin
      sel_write      = p1_write;
      sel_address    = p1_address;
      sel_write_data = p1_write_data;
    end
  end

  // Write enable is a register so async reset drops it mid-access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p0_grant         <= 1'b0;
      p1_grant         <= 1'b0;
      p0_done          <= 1'b0;
      p1_done          <= 1'b0;
      p0_read_data     <= '0;
      p1_read_data     <= '0;
      ram_write_enable <= 1'b0;
      ram_address      <= '0;
      ram_write_data   <= '0;
      owner            <= PORT_LOADER;
      lat_write        <= 1'b0;
    end else begin
      p0_grant         <= load && (pick_port == PORT_LOADER);
      p1_grant         <= load && (pick_port == PORT_CPU);
      p0_done          <= (state == ACCESS) && (owner == PORT_LOADER);
      p1_done          <= (state == ACCESS) && (owner == PORT_CPU);
      ram_write_enable <= load && sel_write;
      if (load) begin
        owner          <= pick_port;
        lat_write      <= sel_write;
        ram_address    <= sel_address;
        ram_write_data <= sel_write_data;
      end
      if ((state == ACCESS) && !lat_write) begin
        if (owner == PORT_LOADER) begin
          p0_read_data <= ram_read_data;
        end else begin
          p1_read_data <= ram_read_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural RAM model.
module tb_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        p0_request = 1'b0, p0_write = 1'b0;
  logic [15:0] p0_address = '0, p0_write_data = '0;
  logic        p1_request = 1'b0, p1_write = 1'b0;
  logic [15:0] p1_address = '0, p1_write_data = '0;
  logic        p0_grant, p0_done, p1_grant, p1_done;
  logic [15:0] p0_read_data, p1_read_data;
  logic        ram_write_enable;
  logic [15:0] ram_address, ram_write_data, ram_read_data;

  int total = 0;
  int bad = 0;
  int we_count = 0;

  // RAM model: unwritten words read as address ^ 0x5AA5.
  bit [15:0] mem [0:65535];
  bit        written [0:65535];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return written[a] ? mem[a] : (a ^ 16'h5AA5);
  endfunction

  assign ram_read_data = mem_word(ram_address);

  always @(posedge clock) begin
    if (ram_write_enable) begin
      mem[ram_address]     <= ram_write_data;
      written[ram_address] <= 1'b1;
      we_count             <= we_count + 1;
    end
  end

  always #5 clock = ~clock;

  ram_arbiter dut (
    .clock            (clock),
    .reset            (reset),
    .p0_request       (p0_request),
    .p0_write         (p0_write),
    .p0_address       (p0_address),
    .p0_write_data    (p0_write_data),
    .p0_grant         (p0_grant),
    .p0_done          (p0_done),
    .p0_read_data     (p0_read_data),
    .p1_request       (p1_request),
    .p1_write         (p1_write),
    .p1_address       (p1_address),
    .p1_write_data    (p1_write_data),
    .p1_grant         (p1_grant),
    .p1_done          (p1_done),
    .p1_read_data     (p1_read_data),
    .ram_write_enable (ram_write_enable),
    .ram_address      (ram_address),
    .ram_write_data   (ram_write_data),
    .ram_read_data    (ram_read_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic handshake(input string tag, input logic g0, input logic g1,
                           input logic d0, input logic d1);
    check({tag, ".p0_grant"}, 32'(p0_grant), 32'(g0));
    check({tag, ".p1_grant"}, 32'(p1_grant), 32'(g1));
    check({tag, ".p0_done"},  32'(p0_done),  32'(d0));
    check({tag, ".p1_done"},  32'(p1_done),  32'(d1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic w;
    // Reset values
    tick();
    handshake("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst.p0_read_data", 32'(p0_read_data), 32'h0);
    check("rst.p1_read_data", 32'(p1_read_data), 32'h0);
    check("rst.ram_we", 32'(ram_write_enable), 32'h0);
    check("rst.ram_address", 32'(ram_address), 32'h0);
    check("rst.ram_write_data", 32'(ram_write_data), 32'h0);
    reset = 1'b0;
    tick();

    // p1 read of 0x0000
    p1_request = 1'b1; p1_write = 1'b0; p1_address = 16'h0000;
    tick();
    handshake("rd0.grant", 1'b0, 1'b1, 1'b0, 1'b0);
    check("rd0.ram_we", 32'(ram_write_enable), 32'h0);
    p1_request = 1'b0;
    tick();
    handshake("rd0.done", 1'b0, 1'b0, 1'b0, 1'b1);
    check("rd0.data", 32'(p1_read_data), 32'h5AA5);
    tick();
    handshake("rd0.after", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rd0.held", 32'(p1_read_data), 32'h5AA5);
    check("rd0.we_count", 32'(we_count), 32'd0);

    // p0 write 0x0001 <- 0x000F then read back
    p0_request = 1'b1; p0_write = 1'b1; p0_address = 16'h0001; p0_write_data = 16'h000F;
    tick();
    handshake("wr1.grant", 1'b1, 1'b0, 1'b0, 1'b0);
    check("wr1.ram_we", 32'(ram_write_enable), 32'h1);
    check("wr1.ram_address", 32'(ram_address), 32'h0001);
    check("wr1.ram_write_data", 32'(ram_write_data), 32'h000F);
    p0_request = 1'b0;
    tick();
    handshake("wr1.done", 1'b0, 1'b0, 1'b1, 1'b0);
    check("wr1.ram_we_off", 32'(ram_write_enable), 32'h0);
    check("wr1.mem", 32'(mem_word(16'h0001)), 32'h000F);
    check("wr1.rd_unchanged", 32'(p0_read_data), 32'h0);
    p0_request = 1'b1; p0_write = 1'b0;
    tick();
    handshake("rd1.grant", 1'b1, 1'b0, 1'b0, 1'b0);
    p0_request = 1'b0;
    tick();
    handshake("rd1.done", 1'b0, 1'b0, 1'b1, 1'b0);
    check("rd1.data", 32'(p0_read_data), 32'h000F);
    check("rd1.we_count", 32'(we_count), 32'd1);
    tick();

    // Both requesting continuously, starting from a fresh pointer
    do_reset();
    p0_request = 1'b1; p0_write = 1'b0; p0_address = 16'h0002;
    p1_request = 1'b1; p1_write = 1'b0; p1_address = 16'h0003;
    for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
      w = (k % 2 == 1);
`else
      w = 1'b0;
`endif
      tick();
      handshake($sformatf("tie%0d.grant", k), !w, w, 1'b0, 1'b0);
      tick();
      handshake($sformatf("tie%0d.done", k), 1'b0, 1'b0, !w, w);
    end
    p0_request = 1'b0; p1_request = 1'b0;
    check("tie.p0_data", 32'(p0_read_data), 32'h5AA7);
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    check("tie.p1_data", 32'(p1_read_data), 32'h5AA6);
`else
    check("tie.p1_starved", 32'(p1_read_data), 32'h0);
`endif
    tick();
    handshake("tie.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // p1 request arriving while p0 write is in ACCESS
    p0_request = 1'b1; p0_write = 1'b1; p0_address = 16'h0004; p0_write_data = 16'h1234;
    tick();
    handshake("pend.p0_grant", 1'b1, 1'b0, 1'b0, 1'b0);
    p0_request = 1'b0;
    p1_request = 1'b1; p1_write = 1'b0; p1_address = 16'h0004;
    tick();
    handshake("pend.p0_done", 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    handshake("pend.p1_grant", 1'b0, 1'b1, 1'b0, 1'b0);
    p1_request = 1'b0;
    tick();
    handshake("pend.p1_done", 1'b0, 1'b0, 1'b0, 1'b1);
    check("pend.p1_data", 32'(p1_read_data), 32'h1234);
    tick();
    handshake("pend.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check("pend.we_count", 32'(we_count), 32'd2);

    // Reset during a write in ACCESS
    p0_request = 1'b1; p0_write = 1'b1; p0_address = 16'h0005; p0_write_data = 16'hBEEF;
    tick();
    check("rstacc.we_before", 32'(ram_write_enable), 32'h1);
    #1;
    reset = 1'b1;
    p0_request = 1'b0;
    #1;
    check("rstacc.we_drop", 32'(ram_write_enable), 32'h0);
    tick();
    handshake("rstacc.no_done", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rstacc.mem", 32'(mem_word(16'h0005)), 32'h5AA0);
    check("rstacc.we_count", 32'(we_count), 32'd2);
    reset = 1'b0;
    tick();
    p0_request = 1'b1; p0_write = 1'b0;
    tick();
    p0_request = 1'b0;
    tick();
    handshake("rstacc.rd_done", 1'b0, 1'b0, 1'b1, 1'b0);
    check("rstacc.rd_data", 32'(p0_read_data), 32'h5AA0);
    tick();

    // Back-to-back p1 reads of 0xFFFF and 0x0000
    p1_request = 1'b1; p1_write = 1'b0; p1_address = 16'hFFFF;
    tick();
    handshake("b2b.g0", 1'b0, 1'b1, 1'b0, 1'b0);
    p1_address = 16'h0000;
    tick();
    handshake("b2b.d0", 1'b0, 1'b0, 1'b0, 1'b1);
    check("b2b.data0", 32'(p1_read_data), 32'hA55A);
    tick();
    handshake("b2b.g1", 1'b0, 1'b1, 1'b0, 1'b0);
    check("b2b.held", 32'(p1_read_data), 32'hA55A);
    check("b2b.ram_address", 32'(ram_address), 32'h0000);
    p1_request = 1'b0;
    tick();
    handshake("b2b.d1", 1'b0, 1'b0, 1'b0, 1'b1);
    check("b2b.data1", 32'(p1_read_data), 32'h5AA5);
    tick();
    handshake("b2b.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    check("b2b.held1", 32'(p1_read_data), 32'h5AA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
